jtframe_romslot_arb: RTL
========================

Name: jtframe_romslot_arb

Overview:
- Round-robin arbiter that shares one SDRAM read port among SLOTS ROM request slots.
- Each slot is a jtframe_romrq-style requester: a level `req` plus `addr_req`, expecting a `din_ok` strobe and 32-bit `din`.
- Sits between the per-chip request slots and the SDRAM controller read port.
- Serialises fetches, forwards the returned data and strobes the winning slot only.

Parameters:
- SLOTS, 4, number of requesting slots (2..8).
- AW, 22, SDRAM word address width; slot addresses arrive already offset to absolute SDRAM addresses.
- TOUT, 255, watchdog limit in clk cycles; used only with JTFRAME_ROMARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- slot_req  in  SLOTS  request level per slot; bit i belongs to slot i.
- slot_addr  in  SLOTS*AW  packed addresses; slot i occupies bits [i*AW +: AW].
- slot_ok  out  SLOTS  one-cycle data-valid strobe, at most one bit set.
- slot_din  out  32  read data, broadcast to all slots.
- sdram_req  out  1  read request to the SDRAM controller.
- sdram_addr  out  AW  read address.
- sdram_ack  in  1  controller accepted the request.
- data_rdy  in  1  controller read data valid.
- data_read  in  32  controller read data.
- timeout  out  1  sticky watchdog flag; tied 0 when the feature is absent.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: sdram_req=0, sdram_addr=0, slot_ok=0, slot_din=0, timeout=0, ptr=0, winner=0, state=IDLE.
- Reset mid-transaction aborts the transaction: no slot_ok pulse is issued, and late data_rdy is ignored.
- States: IDLE, WAIT_ACK, WAIT_DATA, DONE.
- IDLE:
  - If any slot_req is set, winner = first set bit scanning ptr, ptr+1, …, wrapping modulo SLOTS.
  - Register winner; sdram_addr <= slot_addr[winner]; sdram_req <= 1; go to WAIT_ACK.
  - Latency: slot_req seen in cycle n gives sdram_req=1 in cycle n+1.
- WAIT_ACK:
  - Hold sdram_req and sdram_addr stable until sdram_ack.
  - On sdram_ack: sdram_req <= 0.
  - If data_rdy is asserted in the same cycle, treat it as WAIT_DATA completion in that cycle.
  - Otherwise go to WAIT_DATA.
  - data_rdy without sdram_ack in this state is ignored.
- WAIT_DATA:
  - On data_rdy: slot_din <= data_read; slot_ok <= one-hot(winner); ptr <= (winner+1) mod SLOTS; go to DONE.
- DONE:
  - slot_ok is high for exactly this cycle; next cycle slot_ok <= 0 and state goes to IDLE.
  - This gap lets the served slot drop its req before the next arbitration.
  - Earliest next sdram_req is 3 cycles after data_rdy.
- A slot that drops slot_req mid-transaction still gets its slot_ok pulse; no cancellation.
- slot_addr changes after grant are ignored for the transaction in flight.
- Fairness: a continuously requesting slot waits at most SLOTS-1 transactions.
- Single requester: back-to-back service with no starvation.
- slot_din holds its last value between strobes.

Optional Feature:
- Macro: JTFRAME_ROMARB_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter clears on entry to WAIT_ACK and counts in WAIT_ACK and WAIT_DATA.
  - When the count reaches TOUT: drop sdram_req, set timeout=1 (sticky until rst), issue no slot_ok, set ptr <= winner+1, return to IDLE.
  - The stalled slot is re-arbitrated later.
- Without the macro: no counter, timeout tied 0, the arbiter waits indefinitely.

Decomposition:
- Package jtframe_romarb_pkg:
  - state enum (IDLE, WAIT_ACK, WAIT_DATA, DONE);
  - constant SLOTW = $clog2(SLOTS);
  - localparam for timeout counter width.
- One sub-module, jtframe_rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr. Outputs: winner index, any_req.
  - Reused by future write-port arbiters.

Test Plan:
- Reset mid-WAIT_DATA, then data_rdy asserted after reset releases -> no slot_ok; sdram_req=0; state IDLE; all outputs at reset values.
- Slot 2 only, addr 0x012345; ack 2 cycles later, data_rdy 5 cycles later with data 0xDEADBEEF -> sdram_addr=0x012345 held until ack; slot_ok=4'b0100 for one cycle; slot_din=0xDEADBEEF.
- All 4 slots requesting continuously for 8 transactions, ptr=0 at start -> grant order 0,1,2,3,0,1,2,3; never two slot_ok bits set.
- sdram_ack and data_rdy in the same cycle, slot 1 -> slot_ok=4'b0010 the next cycle; no WAIT_DATA cycle; next sdram_req 3 cycles after data_rdy.
- Slot 3 deasserts req one cycle after grant -> transaction completes; slot_ok[3] pulses; arbitration continues with ptr=0.
- With JTFRAME_ROMARB_TIMEOUT_EN and TOUT=16, sdram_ack never asserted -> after 16 cycles sdram_req drops, timeout=1 and stays 1; no slot_ok; next requester granted.

Source files
------------

// File: rtl/jtframe_romarb_pkg.sv
// Shared types and constants for the ROM slot arbiter family.
// Holds the arbiter state encoding, the timeout counter width and a
// helper that sizes slot index fields from a slot count.
package jtframe_romarb_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } arb_state_t;

  // Watchdog counter width; TOUT must fit in it (max 255)
  localparam int TCNT_W = 8;

  // Width of a slot index for n slots, never narrower than one bit
  function automatic int slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: lowest-distance set request from ptr.
// Zero latency, purely combinational.
// No backpressure; the caller decides when to register the winner.
module jtframe_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_req
);

  // One extra bit so ptr+k never wraps before the modulo-N correction
  logic [W:0] cand;

  // Scan from the farthest candidate down so the one nearest ptr wins last
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = |req;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (W+1)'(k);
      if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
      if (req[cand[W-1:0]]) winner = cand[W-1:0];
    end
  end

endmodule

// File: rtl/jtframe_romslot_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM slots.
// Latency: req -> sdram_req 1 cycle; data_rdy -> slot_ok 1 cycle; 3 cycles data_rdy -> next sdram_req.
// Waits on sdram_ack/data_rdy; optional watchdog under JTFRAME_ROMARB_TIMEOUT_EN.
module jtframe_romslot_arb
  import jtframe_romarb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int TOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [31:0]         slot_din,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         data_read,
  output logic                timeout
);

  localparam int SLOTW = slot_w(SLOTS);

  arb_state_t       state;
  logic [SLOTW-1:0] ptr;
  logic [SLOTW-1:0] winner;
  logic [SLOTW-1:0] pick;
  logic             any_req;
  logic [AW-1:0]    addr_arr [SLOTS];

  // Unpack the flat address bus so the winner can index it directly
  for (genvar i = 0; i < SLOTS; i++) begin : g_addr
    assign addr_arr[i] = slot_addr[i*AW +: AW];
  end

  jtframe_rr_pick #(
    .N (SLOTS),
    .W (SLOTW)
  ) u_pick (
    .req     (slot_req),
    .ptr     (ptr),
    .winner  (pick),
    .any_req (any_req)
  );

  // Slot after w, wrapping at SLOTS (SLOTS need not be a power of two)
  function automatic logic [SLOTW-1:0] next_slot(input logic [SLOTW-1:0] w);
    return (int'(w) == SLOTS - 1) ? '0 : w + 1'b1;
  endfunction

`ifdef JTFRAME_ROMARB_TIMEOUT_EN
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TOUT - 1);

  logic [TCNT_W-1:0] tcnt;
  logic              timeout_r;

  assign timeout = timeout_r;
`else
  logic unused_tout;

  assign unused_tout = (TOUT > 0);
  assign timeout     = 1'b0;
`endif

  // Arbitration FSM; every output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      winner     <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      slot_ok    <= '0;
      slot_din   <= '0;
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
      tcnt       <= '0;
      timeout_r  <= 1'b0;
`endif
    end else begin
      // slot_ok is a strobe: low unless a completion below raises it
      slot_ok <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            winner     <= pick;
            sdram_addr <= addr_arr[pick];
            sdram_req  <= 1'b1;
            state      <= WAIT_ACK;
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
            tcnt       <= '0;
`endif
          end
        end

        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (data_rdy) begin
              // Controller returned data in the accept cycle
              slot_din <= data_read;
              slot_ok  <= SLOTS'(1) << winner;
              ptr      <= next_slot(winner);
              state    <= DONE;
            end else begin
              state <= WAIT_DATA;
            end
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
          end else if (tcnt == TLAST) begin
            sdram_req <= 1'b0;
            timeout_r <= 1'b1;
            ptr       <= next_slot(winner);
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
`endif
          end
        end

        WAIT_DATA: begin
          if (data_rdy) begin
            slot_din <= data_read;
            slot_ok  <= SLOTS'(1) << winner;
            ptr      <= next_slot(winner);
            state    <= DONE;
`ifdef JTFRAME_ROMARB_TIMEOUT_EN
          end else if (tcnt == TLAST) begin
            timeout_r <= 1'b1;
            ptr       <= next_slot(winner);
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
`endif
          end
        end

        // One idle cycle so the served slot can drop its request
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
